// File: rtl/pattern_scan_pkg.sv
// Shared types and width helpers for the pattern scan controller.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    // Bits needed to index n items (0..n-1), never less than 1.
    function automatic int unsigned index_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial pattern matcher: bit history, valid-bit count, masked compare
// and overlap handling. o_match is a combinational strobe for the bit
// presented this cycle.
module pattern_match_core
    import pattern_scan_pkg::*;
#(
    parameter int PAT_MAX = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_clear,
    input  logic                         i_bit,
    input  logic                         i_bit_valid,
    input  logic [PAT_MAX-1:0]           i_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] i_len,
    input  logic                         i_overlap,
    output logic                         o_match
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);

    logic [PAT_MAX-1:0] hist;
    logic [PAT_MAX-1:0] hist_next;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_next;

    // Next history/count and masked compare against the low L pattern bits.
    always_comb begin
        hist_next = {hist[PAT_MAX-2:0], i_bit};
        cnt_next  = (cnt == LEN_W'(PAT_MAX)) ? cnt : cnt + LEN_W'(1);
        mask      = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            mask[i] = (LEN_W'(i) < i_len);
        end
        o_match = i_bit_valid && (i_len != '0) && (cnt_next >= i_len) &&
                  (((hist_next ^ i_pattern) & mask) == '0);
    end

    // History and count update; a non-overlapping match restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clear) begin
            hist <= '0;
            cnt  <= '0;
        end else if (i_bit_valid) begin
            hist <= hist_next;
            cnt  <= (o_match && !i_overlap) ? '0 : cnt_next;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-fed pattern scanner: accepts a word, shifts it MSB first into the
// match core, and reports per-bit detects, per-word hits and total matches.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_cfg_we,
    input  logic [PAT_MAX-1:0]           i_cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] i_cfg_len,
    input  logic                         i_cfg_overlap,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DATA_W-1:0]            i_data,
    output logic                         o_detect,
    output logic                         o_done,
    output logic [$clog2(DATA_W+1)-1:0]  o_word_hits,
    output logic [CNT_W-1:0]             o_match_cnt
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);
    localparam int HIT_W = $clog2(DATA_W + 1);
    localparam int BIT_W = index_w(DATA_W);

    scan_state_t        state;
    scan_state_t        state_next;
    logic               accept;
    logic               cfg_write;
    logic               last_bit;
    logic               match;
    logic               shifting;
    logic [DATA_W-1:0]  sreg;
    logic [BIT_W-1:0]   bit_idx;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_done     = 1'b0;
        shifting   = 1'b0;
        last_bit   = (bit_idx == BIT_W'(DATA_W - 1));
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = SHIFT;
            end
            SHIFT: begin
                shifting = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept    = o_ready && i_valid;
        cfg_write = o_ready && i_cfg_we;
    end

    // Config latch (IDLE only), shift register, bit counter and counters.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cfg_pattern <= '0;
            cfg_len     <= '0;
            cfg_overlap <= 1'b0;
            sreg        <= '0;
            bit_idx     <= '0;
            o_detect    <= 1'b0;
            o_word_hits <= '0;
            o_match_cnt <= '0;
        end else begin
            o_detect <= match;
            if (cfg_write) begin
                cfg_pattern <= i_cfg_pattern;
                cfg_len     <= (i_cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : i_cfg_len;
                cfg_overlap <= i_cfg_overlap;
                o_match_cnt <= '0;
            end else if (match && (o_match_cnt != '1)) begin
                o_match_cnt <= o_match_cnt + CNT_W'(1);
            end
            if (accept) begin
                sreg        <= i_data;
                bit_idx     <= '0;
                o_word_hits <= '0;
            end else if (shifting) begin
                sreg    <= {sreg[DATA_W-2:0], 1'b0};
                bit_idx <= bit_idx + BIT_W'(1);
                if (match) o_word_hits <= o_word_hits + HIT_W'(1);
            end
        end
    end

    pattern_match_core #(
        .PAT_MAX (PAT_MAX)
    ) u_core (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_clear     (cfg_write),
        .i_bit       (sreg[DATA_W-1]),
        .i_bit_valid (shifting),
        .i_pattern   (cfg_pattern),
        .i_len       (cfg_len),
        .i_overlap   (cfg_overlap),
        .o_match     (match)
    );

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Programmable serial pattern-scan controller. It accepts parallel data words over a valid/ready handshake and serializes each word MSB-first into a configurable pattern matcher of up to PAT_MAX bits, with overlap or non-overlap detection. It reports per-bit detect pulses, a per-word hit count and a saturating total match count. It generalizes the fixed-pattern serial detectors in the sequential blocks into a word-fed, software-configurable scanner.

Parameters:
DATA_W, 8, input word width; bits scanned per word.
PAT_MAX, 8, maximum pattern length in bits.
CNT_W, 16, width of the saturating total match counter.

Ports:
i_clk  input  1  clock; all logic on the rising edge.
i_rstn  input  1  synchronous active-low reset.
i_cfg_we  input  1  config write strobe; honoured only in IDLE.
i_cfg_pattern  input  PAT_MAX  pattern; bit 0 is the most recently received bit.
i_cfg_len  input  $clog2(PAT_MAX+1)  pattern length; 0 disables matching.
i_cfg_overlap  input  1  1 = overlapping matches allowed.
i_valid  input  1  input word valid.
o_ready  output  1  controller can accept a word.
i_data  input  DATA_W  input word, scanned MSB first.
o_detect  output  1  registered one-cycle pulse per matching bit position.
o_done  output  1  one-cycle pulse; word scan complete.
o_word_hits  output  $clog2(DATA_W+1)  match count for the last word; valid when o_done=1, held until next accept.
o_match_cnt  output  CNT_W  saturating total matches since reset or config write.

Behaviour:
- Reset (i_rstn=0 at a rising edge): state IDLE; history, valid-bit count, shift register, counters and config registers all 0; o_detect=0; o_done=0; o_word_hits=0; o_match_cnt=0. The block then reports o_ready=1. Reset mid-scan aborts the word with no o_done.
- FSM states:
  - IDLE: o_ready=1. On i_valid&&o_ready, load i_data into the shift register, clear the word hit count, go to SHIFT.
  - SHIFT: lasts exactly DATA_W cycles; o_ready=0. Each cycle, shift the current MSB into the history register (PAT_MAX bits, new bit enters at bit 0) and increment the valid-bit count (saturating at PAT_MAX). After the DATA_W-th bit, go to DONE.
  - DONE: one cycle; o_done=1, o_ready=0. Then go to IDLE.
- Accept-to-done latency is DATA_W+1 cycles. A back-to-back word is accepted in the cycle after DONE, so throughput is one word per DATA_W+2 cycles.
- Match condition, evaluated on the updated history:
  - the effective length L = min(cfg_len, PAT_MAX) is nonzero;
  - the valid-bit count is at least L;
  - history[L-1:0] equals pattern[L-1:0].
- On a match:
  - o_detect=1 in the next cycle; the detect for the last bit coincides with DONE;
  - the word hit count increments, and the final o_word_hits includes the last bit;
  - o_match_cnt increments, saturating at all-ones;
  - if overlap=0, the valid-bit count is cleared to 0.
- History and valid-bit count persist across words, so a pattern can span a word boundary.
- Config write in IDLE: latch pattern, len and overlap; clear history, valid-bit count and o_match_cnt. A write in IDLE coinciding with i_valid is applied first, and the accepted word is scanned with the new config. i_cfg_we in SHIFT or DONE is ignored.
- i_cfg_len > PAT_MAX is clamped to PAT_MAX. len=0 still consumes words and pulses o_done with 0 hits.

Decomposition:
- Package pattern_scan_pkg holds the FSM state enum (IDLE, SHIFT, DONE) and localparam width helpers.
- One natural sub-module, pattern_match_core: history register, valid-bit count, masked compare and overlap clear. It takes a bit plus a bit-valid strobe and returns a match strobe.
- The top level holds the FSM, shift register, handshake and counters.

Test Plan:
- Pattern 0x0F, len 4, overlap 1; word 0xFF -> o_detect pulses for bits 3..7; o_word_hits=5; o_match_cnt=5.
- Same config with overlap 0; word 0xFF -> matches at bits 3 and 7; o_word_hits=2; o_match_cnt=2.
- Pattern 0x0F, len 4, overlap 1; words 0x03 then 0xC0 -> o_word_hits 0 then 1 (cross-word match at bit 1 of the second word); o_match_cnt=1.
- Pattern 0x02 ("10"), len 2; word 0xAA with overlap 1 and again with overlap 0 -> o_word_hits=4 in both runs; o_done exactly DATA_W+1 cycles after accept; o_ready=0 throughout SHIFT/DONE.
- Config write during SHIFT (len=1, pattern=0) -> ignored; the result matches the old config. A config write in IDLE clears o_match_cnt to 0.
- CNT_W=4, pattern len 1 = "1", words 0xFF, 0xFF -> o_match_cnt saturates at 15. i_rstn=0 mid-SHIFT -> next cycle o_ready=1, o_match_cnt=0, no o_done.
